// File: rtl/acc_pkg.sv
// Shared types and helpers for the accumulator bank.
package acc_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LOAD = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_SHL  = 3'b100,
    OP_SHR  = 3'b101,
    OP_CLR  = 3'b110,
    OP_MUL  = 3'b111
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

  // Counter width for the default 8-bit bank; instances use mul_cnt_w(WIDTH).
  localparam int ACC_WIDTH_DEF = 8;
  localparam int MUL_CNT_W     = $clog2(ACC_WIDTH_DEF + 1);

  function automatic int mul_cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/acc_alu.sv
// Combinational unit for every single-cycle accumulator op.
module acc_alu
  import acc_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int SAT_EN = 0
) (
  input  logic [WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0] i_data,
  input  op_e              i_op,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_diff;

  assign w_sum  = {1'b0, i_acc} + {1'b0, i_data};
  assign w_diff = {1'b0, i_acc} - {1'b0, i_data};

  // Result and carry/borrow/shift-out per op; saturation keeps the flag.
  always_comb begin
    o_result = i_acc;
    o_carry  = 1'b0;
    case (i_op)
      OP_LOAD: o_result = i_data;
      OP_ADD: begin
        o_carry  = w_sum[WIDTH];
        o_result = (SAT_EN != 0 && w_sum[WIDTH]) ? '1 : w_sum[WIDTH-1:0];
      end
      OP_SUB: begin
        o_carry  = w_diff[WIDTH];
        o_result = (SAT_EN != 0 && w_diff[WIDTH]) ? '0 : w_diff[WIDTH-1:0];
      end
      OP_SHL: begin
        o_carry  = i_acc[WIDTH-1];
        o_result = {i_acc[WIDTH-2:0], 1'b0};
      end
      OP_SHR: begin
        o_carry  = i_acc[0];
        o_result = {1'b0, i_acc[WIDTH-1:1]};
      end
      OP_CLR:  o_result = '0;
      default: ;
    endcase
  end

endmodule

// File: rtl/acc_bank.sv
// Bank of NUM_ACC accumulators with single-cycle ALU ops and a
// shift-add multiply that holds the bank busy for WIDTH cycles.
module acc_bank
  import acc_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int NUM_ACC = 4,
  parameter int SAT_EN  = 0,
  localparam int SELW   = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op,
  input  logic [SELW-1:0]  acc_sel,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SELW-1:0]  rd_sel,
  output logic [WIDTH-1:0] acc_out,
  output logic             carry_flag,
  output logic             zero_flag,
  output logic             done,
  output logic             busy
);

  localparam int                CNT_W = mul_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);
  localparam logic [SELW:0]     NACC  = (SELW + 1)'(NUM_ACC);

  logic [NUM_ACC-1:0][WIDTH-1:0] r_acc;
  state_e                        r_state, w_state_nxt;
  logic                          r_carry, r_zero, r_done;
  logic [2*WIDTH-1:0]            r_prod, r_mcand, w_prod_nxt;
  logic [WIDTH-1:0]              r_mplier;
  logic [CNT_W-1:0]              r_cnt;
  logic [SELW-1:0]               r_tgt;

  op_e              w_op;
  logic             w_accept, w_sel_ok, w_rd_ok, w_last;
  logic [WIDTH-1:0] w_acc_cur, w_alu_res, w_mul_res;
  logic             w_alu_c, w_mul_hi;

  assign w_op      = op_e'(op);
  assign op_ready  = (r_state == IDLE);
  assign busy      = (r_state == MUL);
  assign w_accept  = op_valid && op_ready;
  assign w_sel_ok  = ({1'b0, acc_sel} < NACC);
  assign w_rd_ok   = ({1'b0, rd_sel} < NACC);
  assign w_acc_cur = w_sel_ok ? r_acc[acc_sel] : '0;
  assign acc_out   = w_rd_ok ? r_acc[rd_sel] : '0;
  assign w_last    = (r_cnt == LAST);

  // Last iteration folds its own add in so the write lands at edge N+WIDTH.
  assign w_prod_nxt = r_prod + (r_mplier[0] ? r_mcand : '0);
  assign w_mul_hi   = |w_prod_nxt[2*WIDTH-1:WIDTH];
  assign w_mul_res  = (SAT_EN != 0 && w_mul_hi) ? '1 : w_prod_nxt[WIDTH-1:0];

  assign carry_flag = r_carry;
  assign zero_flag  = r_zero;
  assign done       = r_done;

  acc_alu #(.WIDTH(WIDTH), .SAT_EN(SAT_EN)) u_alu (
    .i_acc    (w_acc_cur),
    .i_data   (data_in),
    .i_op     (w_op),
    .o_result (w_alu_res),
    .o_carry  (w_alu_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state: enter MUL on an accepted in-range MUL, leave after WIDTH steps.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept && w_sel_ok && w_op == OP_MUL) w_state_nxt = MUL;
      MUL:  if (w_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Accumulators, flags, done pulse and the multiply shifter/counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc    <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
      r_done   <= 1'b0;
      r_prod   <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_tgt    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept && w_sel_ok) begin
            if (w_op == OP_MUL) begin
              r_mcand  <= {{WIDTH{1'b0}}, w_acc_cur};
              r_mplier <= data_in;
              r_tgt    <= acc_sel;
              r_prod   <= '0;
              r_cnt    <= '0;
            end else if (w_op != OP_NOP) begin
              r_acc[acc_sel] <= w_alu_res;
              r_carry        <= w_alu_c;
              r_zero         <= (w_alu_res == '0);
              r_done         <= 1'b1;
            end
          end
        end
        MUL: begin
          r_prod   <= w_prod_nxt;
          r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_acc[r_tgt] <= w_mul_res;
            r_carry      <= w_mul_hi;
            r_zero       <= (w_mul_res == '0);
            r_done       <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_bank.sv
// Bench: a plain (SAT_EN=0) and a saturating (SAT_EN=1) bank driven in
// lockstep, checked against directed tables and an arithmetic model.
module tb_acc_bank;
  import acc_pkg::*;

  logic       clk = 1'b0;
  logic       reset, op_valid;
  logic [2:0] op;
  logic [1:0] acc_sel, rd_sel;
  logic [7:0] data_in;

  logic       rdy0, rdy1, c0, c1, z0, z1, dn0, dn1, bs0, bs1;
  logic [7:0] ao0, ao1;

  int nvec = 0;
  int nerr = 0;

  // Model state: [dut][acc]
  int m_acc [2][4];
  int m_c   [2];
  int m_z   [2];

  always #5 clk = ~clk;

  acc_bank #(.WIDTH(8), .NUM_ACC(4), .SAT_EN(0)) dut0 (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(rdy0), .op(op),
    .acc_sel(acc_sel), .data_in(data_in), .rd_sel(rd_sel), .acc_out(ao0),
    .carry_flag(c0), .zero_flag(z0), .done(dn0), .busy(bs0));

  acc_bank #(.WIDTH(8), .NUM_ACC(4), .SAT_EN(1)) dut1 (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(rdy1), .op(op),
    .acc_sel(acc_sel), .data_in(data_in), .rd_sel(rd_sel), .acc_out(ao1),
    .carry_flag(c1), .zero_flag(z1), .done(dn1), .busy(bs1));

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 4; a++) m_acc[k][a] = 0;
      m_c[k] = 0;
      m_z[k] = 0;
    end
  endtask

  // Arithmetic reference: results from plain integer maths and the op rules.
  task automatic model_apply(input int o, input int s, input int d);
    int a, r, c, full;
    if (o == 0) return;
    for (int k = 0; k < 2; k++) begin
      a = m_acc[k][s];
      c = 0;
      r = 0;
      case (o)
        1: r = d;
        2: begin full = a + d; c = (full > 255); r = c ? (k ? 255 : full - 256) : full; end
        3: begin c = (a < d); r = c ? (k ? 0 : a - d + 256) : a - d; end
        4: begin c = a / 128; r = (a * 2) % 256; end
        5: begin c = a % 2; r = a / 2; end
        6: r = 0;
        default: begin full = a * d; c = (full > 255); r = (c && k) ? 255 : full % 256; end
      endcase
      m_acc[k][s] = r;
      m_c[k]      = c;
      m_z[k]      = (r == 0);
    end
  endtask

  task automatic check_state(input string tag, input int s, input bit exp_done);
    chk({tag, "_acc0"}, ao0, m_acc[0][s]);
    chk({tag, "_acc1"}, ao1, m_acc[1][s]);
    chk({tag, "_c0"}, c0, m_c[0]);
    chk({tag, "_c1"}, c1, m_c[1]);
    chk({tag, "_z0"}, z0, m_z[0]);
    chk({tag, "_z1"}, z1, m_z[1]);
    chk({tag, "_done0"}, dn0, exp_done);
    chk({tag, "_done1"}, dn1, exp_done);
  endtask

  // Issue one op; for MUL, watch busy and optionally poke an ADD mid-flight.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [1:0] s,
                        input logic [7:0] d, input bit poke);
    int nb;
    @(negedge clk);
    op_valid = 1'b1; op = o; acc_sel = s; data_in = d; rd_sel = s;
    @(negedge clk);
    op_valid = 1'b0;
    if (o == 3'b111) begin
      nb = 0;
      chk({tag, "_old_rd"}, ao0, m_acc[0][s]);
      while (bs0 && nb < 20) begin
        chk({tag, "_rdy_busy"}, {rdy0, rdy1, bs1}, 3'b001);
        if (poke && nb == 2) begin
          op_valid = 1'b1; op = 3'b010; acc_sel = ~s; data_in = 8'($urandom);
        end
        if (nb == 5) op_valid = 1'b0;
        nb++;
        @(negedge clk);
      end
      op_valid = 1'b0;
      chk({tag, "_busy_cycles"}, nb, 8);
      chk({tag, "_rdy_after"}, {rdy0, rdy1, bs0, bs1}, 4'b1100);
    end
    model_apply(int'(o), int'(s), int'(d));
    check_state(tag, int'(s), o != 3'b000);
  endtask

  typedef struct {
    logic [2:0] op;
    logic [1:0] sel;
    logic [7:0] d;
    logic [7:0] a0;
    logic       c0, z0;
    logic [7:0] a1;
    logic       c1, z1;
  } vec_t;

  vec_t tbl [13];

  initial begin
    tbl[0]  = '{OP_LOAD, 2'd0, 8'hFF, 8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};
    tbl[1]  = '{OP_ADD,  2'd0, 8'h01, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[2]  = '{OP_LOAD, 2'd2, 8'h03, 8'h03, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0};
    tbl[3]  = '{OP_SUB,  2'd2, 8'h05, 8'hFE, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[4]  = '{OP_SHR,  2'd2, 8'h99, 8'h7F, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[5]  = '{OP_SHL,  2'd2, 8'h99, 8'hFE, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[6]  = '{OP_LOAD, 2'd1, 8'h0C, 8'h0C, 1'b0, 1'b0, 8'h0C, 1'b0, 1'b0};
    tbl[7]  = '{OP_MUL,  2'd1, 8'h0A, 8'h78, 1'b0, 1'b0, 8'h78, 1'b0, 1'b0};
    tbl[8]  = '{OP_LOAD, 2'd3, 8'h20, 8'h20, 1'b0, 1'b0, 8'h20, 1'b0, 1'b0};
    tbl[9]  = '{OP_MUL,  2'd3, 8'h10, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[10] = '{OP_NOP,  2'd3, 8'h55, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[11] = '{OP_CLR,  2'd0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1};
    tbl[12] = '{OP_ADD,  2'd1, 8'hF0, 8'h68, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};

    reset = 1'b1; op_valid = 1'b0; op = 3'b000; acc_sel = 2'd0;
    data_in = 8'h00; rd_sel = 2'd0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset state
    for (int a = 0; a < 4; a++) begin
      rd_sel = 2'(a);
      #1;
      chk("rst_acc0", ao0, 0);
      chk("rst_acc1", ao1, 0);
    end
    chk("rst_flags", {c0, z0, dn0, bs0, c1, z1, dn1, bs1}, 8'h00);
    chk("rst_ready", {rdy0, rdy1}, 2'b11);

    // Directed table; the MUL row also presents an ADD mid-multiply.
    for (int i = 0; i < 13; i++) begin
      run_op($sformatf("tbl%0d", i), tbl[i].op, tbl[i].sel, tbl[i].d, tbl[i].op == OP_MUL);
      chk($sformatf("tbl%0d_vec0", i), {ao0, c0, z0}, {tbl[i].a0, tbl[i].c0, tbl[i].z0});
      chk($sformatf("tbl%0d_vec1", i), {ao1, c1, z1}, {tbl[i].a1, tbl[i].c1, tbl[i].z1});
    end

    // done is a single-cycle pulse
    @(negedge clk);
    chk("done_pulse_end", {dn0, dn1}, 2'b00);

    // Reset in the middle of a multiply
    run_op("pre_abort", OP_LOAD, 2'd1, 8'h0C, 1'b0);
    @(negedge clk);
    op_valid = 1'b1; op = OP_MUL; acc_sel = 2'd1; data_in = 8'h0A;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_busy_pre", {bs0, bs1}, 2'b11);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    chk("abort_ctl", {bs0, bs1, rdy0, rdy1, dn0, dn1}, 6'b001100);
    for (int a = 0; a < 4; a++) begin
      rd_sel = 2'(a);
      #1;
      chk("abort_acc", {ao0, ao1}, 16'h0000);
    end
    chk("abort_flags", {c0, z0, c1, z1}, 4'b0000);
    repeat (12) begin
      @(negedge clk);
      chk("abort_no_done", {dn0, dn1, bs0, bs1}, 4'b0000);
    end
    run_op("post_abort", OP_LOAD, 2'd1, 8'hAA, 1'b0);

    // Randomized ops against the model
    for (int i = 0; i < 80; i++) begin
      run_op($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
             8'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/acc_bank.md
Name: acc_bank

Overview:
Parametrised successor to the single 8-bit accumulator register: a bank of NUM_ACC accumulators of WIDTH bits.
- Accepts ops through a valid/ready handshake.
- Single-cycle ops: LOAD, ADD, SUB, SHL, SHR, CLR.
- Multi-cycle shift-add multiply (MUL) with a busy FSM.
- Status flags, optional saturation, independent read port.
- Sits between the datapath bus and the control sequencer as the CPU's working-register file.

Parameters:
WIDTH, 8, accumulator and data_in width (>=2)
NUM_ACC, 4, number of accumulators (>=1; selector width SELW = max(1, clog2(NUM_ACC)))
SAT_EN, 0, 1 = ADD/MUL clamp to all-ones and SUB clamps to 0 on carry/borrow

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high; clears everything
op_valid  in  1  op request
op_ready  out  1  bank can accept an op this cycle
op  in  3  000 NOP, 001 LOAD, 010 ADD, 011 SUB, 100 SHL, 101 SHR, 110 CLR, 111 MUL
acc_sel  in  SELW  target accumulator of the op
data_in  in  WIDTH  operand
rd_sel  in  SELW  read-port select
acc_out  out  WIDTH  acc[rd_sel], combinational from registers
carry_flag  out  1  carry/borrow/shifted-out bit of last completed op
zero_flag  out  1  result of last completed op == 0
done  out  1  one-cycle pulse after an op completes
busy  out  1  MUL in progress

Behaviour:
- Reset values (sampled with reset=1 at an edge): all acc = 0, carry_flag = 0, zero_flag = 0, done = 0, busy = 0, state = IDLE. Reset overrides any op in the same cycle.
- FSM states: IDLE and MUL.
- op_ready = (state == IDLE). An op is accepted when op_valid && op_ready at an edge. op_valid while busy is ignored and not queued.
- Single-cycle ops, accepted at edge N:
  - acc[acc_sel] updated at edge N.
  - Flags updated at edge N.
  - done = 1 for the cycle after edge N.
- NOP: accepted, but no change to acc or flags, and no done pulse.
- LOAD: acc = data_in; carry = 0.
- ADD: {carry, r} = acc + data_in.
- SUB: r = acc - data_in; carry = borrow (acc < data_in).
- SHL: carry = acc[WIDTH-1]; r = acc << 1. data_in is ignored.
- SHR (logical): carry = acc[0]; r = acc >> 1.
- CLR: r = 0; carry = 0.
- Saturation (SAT_EN = 1): ADD with carry gives r = all-ones; SUB with borrow gives r = 0. The carry flag still reports the event.
- zero_flag = (final written value == 0), evaluated after saturation.
- MUL, accepted at edge N:
  - Latch multiplicand = acc[acc_sel], multiplier = data_in, target index.
  - Clear a 2*WIDTH partial product; busy = 1; go to MUL.
  - One shift-add iteration per cycle, WIDTH iterations.
  - At edge N+WIDTH: acc[target] = low WIDTH bits of the product (all-ones if SAT_EN and high half != 0); carry_flag = (high half != 0); zero_flag per the rule above. Return to IDLE, busy = 0.
  - done pulses for the cycle after edge N+WIDTH.
  - Operands are latched, so data_in and acc_sel changes during MUL have no effect.
- rd_sel is unaffected by busy; reading the MUL target during MUL returns its old value.
- Reset mid-MUL: aborts, all state cleared, no done pulse.
- Out-of-range acc_sel/rd_sel (NUM_ACC not a power of 2): the op is accepted as a no-op with no flag update and no done; acc_out reads 0.

Decomposition:
- Package acc_pkg:
  - op_e enum (3-bit op codes).
  - state_e {IDLE, MUL}.
  - Localparam for the MUL iteration counter width, clog2(WIDTH+1).
- Sub-module acc_alu: purely combinational single-cycle op unit. Inputs acc, data_in, op, SAT_EN; outputs result, carry.
- acc_bank holds the register array, the FSM and the MUL shifter/counter.

Test Plan (WIDTH=8, NUM_ACC=4):
1. Reset 2 cycles; LOAD 0xFF into acc0 -> acc_out(rd_sel=0) = 0xFF; zero = 0; carry = 0; done pulse 1 cycle.
2. ADD 0x01 to acc0 = 0xFF -> acc0 = 0x00, carry = 1, zero = 1. Same stimulus with SAT_EN=1 -> acc0 = 0xFF, carry = 1, zero = 0.
3. acc2 = 0x03; SUB 0x05 -> 0xFE, carry = 1. Then SHR -> 0x7F, carry = 0. Then SHL -> 0xFE, carry = 0.
4. acc1 = 0x0C; MUL 0x0A -> busy and !op_ready for 8 cycles; acc1 = 0x78, carry = 0; done 1 cycle after. An ADD presented mid-MUL is ignored.
5. acc3 = 0x20; MUL 0x10 -> acc3 = 0x00, carry = 1, zero = 1. With SAT_EN=1 -> 0xFF.
6. Start MUL on acc1 = 0x0C, assert reset at iteration 4 -> all acc = 0, busy = 0, op_ready = 1, no done. A LOAD 0xAA on the next cycle succeeds.
